decode_dispatch_ctrl: RTL and testbench

- Instruction buffer and issue sequencer between fetch and the instruction decoder.
- Buffers fetched instructions with PC and branch prediction, then presents them one per cycle to the decoder/dispatch path over a valid/ready handshake.
- Serializes SYSTEM-opcode instructions (ecall and friends): the ROB must drain before issue, and issue stays blocked until it drains again.
- Discards all buffered state on a pipeline flush.

---
 rtl/decode_dispatch_ctrl_pkg.sv | 35 +++
 rtl/decode_dispatch_ctrl_sync_fifo.sv | 70 +++++++
 rtl/decode_dispatch_ctrl.sv | 140 ++++++++++++++
 tb/tb_decode_dispatch_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_dispatch_ctrl_pkg.sv
// Shared definitions for the decode/dispatch issue sequencer: the SYSTEM
// opcode, the sequencer state encoding and the buffered fetch entry layout.
package decode_dispatch_ctrl_pkg;

    // Default machine widths: one instruction word and one data/PC word.
    localparam int INSTRUCTION_SIZE = 32;
    localparam int DATA_SIZE        = 64;

    // Major opcode shared by ecall, ebreak, CSR accesses and the like.
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // RUN   : normal in-order issue.
    // DRAIN : SYSTEM instruction at the head, waiting for the ROB to empty.
    // ISSUE : SYSTEM instruction offered alone to dispatch.
    // WAIT  : SYSTEM instruction dispatched, waiting for it to retire.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } dd_state_t;

    // One buffered fetch slot at the default widths.
    typedef struct packed {
        logic [INSTRUCTION_SIZE-1:0] instr;
        logic [DATA_SIZE-1:0]        pc;
        logic                        pred;
    } fetch_entry_t;

    // True when the opcode field selects the SYSTEM major opcode.
    function automatic logic is_system_op(input logic [6:0] opcode);
        return opcode == OP_SYSTEM;
    endfunction

endpackage : decode_dispatch_ctrl_pkg

// File: rtl/decode_dispatch_ctrl_sync_fifo.sv
// Single-clock circular FIFO with occupancy count and a synchronous flush.
// The head entry is presented combinationally so the consumer can see it in
// the cycle after it was written; an empty FIFO presents all zeros.
module sync_fifo #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // A flush cancels both sides; overflow and underflow are ignored so a
    // misbehaving producer or consumer cannot corrupt the pointers.
    assign do_push = push && !full  && !flush;
    assign do_pop  = pop  && !empty && !flush;

    assign count = count_q;
    assign rdata = empty ? '0 : mem_q[head_q];

    // Storage write; no reset needed since validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[tail_q] <= wdata;
        end
    end

    // Pointer and occupancy update; DEPTH is a power of two so the pointers
    // wrap naturally at their own width.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (do_pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule : sync_fifo

// File: rtl/decode_dispatch_ctrl.sv
// Instruction buffer and issue sequencer between fetch and decode.
// Buffers {instr, pc, pred} and offers the head one per cycle to dispatch.
// SYSTEM-opcode instructions are serialized: the ROB must be empty before
// one is offered, and nothing else issues until it has retired.
module decode_dispatch_ctrl
    import decode_dispatch_ctrl_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = INSTRUCTION_SIZE,
    parameter int ADDR_W  = DATA_SIZE
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               fetch_valid,
    output logic               fetch_ready,
    input  logic [INSTR_W-1:0] fetch_instr,
    input  logic [ADDR_W-1:0]  fetch_pc,
    input  logic               fetch_pred_taken,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic               dec_pred_taken,
    input  logic               rob_empty,
    output logic               serializing,
    output logic [31:0]        serialize_stalls
);

    localparam int ENTRY_W = INSTR_W + ADDR_W + 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic [CNT_W-1:0]   fifo_count;
    logic               buf_empty;
    logic               buf_full;
    logic               is_sys;
    logic               do_push;
    logic               do_pop;

    dd_state_t          state_q;
    logic               serializing_q;
    logic [31:0]        stalls_q;

    assign buf_empty = (fifo_count == '0);
    assign buf_full  = (fifo_count == CNT_W'(DEPTH));

    // Acceptance is independent of dec_ready: a full buffer stays closed even
    // in a cycle where the head is being consumed.
    assign fetch_ready = !buf_full && !flush;
    assign do_push     = fetch_valid && fetch_ready;
    assign do_pop      = dec_valid && dec_ready;

    assign wr_entry = {fetch_instr, fetch_pc, fetch_pred_taken};
    assign {dec_instr, dec_pc, dec_pred_taken} = rd_entry;

    assign is_sys = !buf_empty && is_system_op(dec_instr[6:0]);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (do_push),
        .pop     (do_pop),
        .wdata   (wr_entry),
        .rdata   (rd_entry),
        .count   (fifo_count)
    );

    // Offer gating: a SYSTEM head is only offered from ISSUE, and nothing is
    // offered while draining or waiting for a SYSTEM instruction to retire.
    always_comb begin
        dec_valid = 1'b0;
        unique case (state_q)
            RUN:     dec_valid = !buf_empty && !is_sys;
            DRAIN:   dec_valid = 1'b0;
            ISSUE:   dec_valid = !buf_empty;
            WAIT:    dec_valid = 1'b0;
            default: dec_valid = 1'b0;
        endcase
    end

    // Serialization sequencer with a registered "not in RUN" flag. The WAIT
    // exit samples rob_empty only from the cycle after the pop onwards, since
    // the popped instruction has not yet reached the ROB in the pop cycle.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            state_q       <= RUN;
            serializing_q <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (is_sys) begin
                        state_q       <= rob_empty ? ISSUE : DRAIN;
                        serializing_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (rob_empty) begin
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (do_pop) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (rob_empty) begin
                        state_q       <= RUN;
                        serializing_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= RUN;
                    serializing_q <= 1'b0;
                end
            endcase
        end
    end

    assign serializing = serializing_q;

    // Saturating count of cycles where work is buffered but nothing is
    // offered; survives flushes so it measures total serialization cost.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stalls_q <= '0;
        end else if (!buf_empty && !dec_valid && !flush && (stalls_q != '1)) begin
            stalls_q <= stalls_q + 32'd1;
        end
    end

    assign serialize_stalls = stalls_q;

endmodule : decode_dispatch_ctrl

// File: tb/tb_decode_dispatch_ctrl.sv
// Randomized scoreboard bench for decode_dispatch_ctrl.
module tb_decode_dispatch_ctrl;
    import decode_dispatch_ctrl_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [31:0] ADDI  = 32'h0010_0093;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [31:0] fetch_instr = '0;
    logic [63:0] fetch_pc = '0;
    logic        fetch_pred_taken = 1'b0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [63:0] dec_pc;
    logic        dec_pred_taken;
    logic        rob_empty = 1'b1;
    logic        serializing;
    logic [31:0] serialize_stalls;

    always #5 clk = ~clk;

    decode_dispatch_ctrl #(
        .DEPTH   (DEPTH),
        .INSTR_W (32),
        .ADDR_W  (64)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .flush            (flush),
        .fetch_valid      (fetch_valid),
        .fetch_ready      (fetch_ready),
        .fetch_instr      (fetch_instr),
        .fetch_pc         (fetch_pc),
        .fetch_pred_taken (fetch_pred_taken),
        .dec_valid        (dec_valid),
        .dec_ready        (dec_ready),
        .dec_instr        (dec_instr),
        .dec_pc           (dec_pc),
        .dec_pred_taken   (dec_pred_taken),
        .rob_empty        (rob_empty),
        .serializing      (serializing),
        .serialize_stalls (serialize_stalls)
    );

    int tests = 0;
    int fails = 0;

    // Scoreboard: entries accepted by the buffer, oldest first.
    fetch_entry_t exp_q[$];

    // Reference model of the serialization rules:
    //  m_blocked : a SYSTEM instruction was dispatched and has not yet been
    //              seen retired (rob_empty sampled after the dispatch cycle).
    //  m_seen    : a SYSTEM head has been noticed while unblocked.
    //  m_ok      : the ROB was seen empty while that SYSTEM head waited.
    bit          m_blocked, m_seen, m_ok;
    logic [31:0] m_stalls;

    fetch_entry_t hd;
    bit           m_empty, m_sys, m_ev, m_pop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: evaluates the model mid-cycle, compares, then advances the model.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            m_blocked = 0;
            m_seen    = 0;
            m_ok      = 0;
            m_stalls  = '0;
        end else begin
            m_empty = (exp_q.size() == 0);
            hd      = m_empty ? '0 : exp_q[0];
            m_sys   = !m_empty && (hd.instr[6:0] == 7'h73);
            m_ev    = !m_empty && !m_blocked && (!m_sys || m_ok);

            chk("dec_valid", 64'(dec_valid), 64'(m_ev));
            chk("fetch_ready", 64'(fetch_ready), 64'((exp_q.size() < DEPTH) && !flush));
            chk("serializing", 64'(serializing), 64'(m_blocked || m_seen));
            chk("serialize_stalls", 64'(serialize_stalls), 64'(m_stalls));
            if (m_ev) begin
                chk("dec_instr", 64'(dec_instr), 64'(hd.instr));
                chk("dec_pc", dec_pc, hd.pc);
                chk("dec_pred", 64'(dec_pred_taken), 64'(hd.pred));
            end else if (m_empty) begin
                chk("empty_head_zero",
                    64'((dec_instr != '0) || (dec_pc != '0) || dec_pred_taken), 64'(0));
            end

            if (flush) begin
                exp_q.delete();
                m_blocked = 0;
                m_seen    = 0;
                m_ok      = 0;
            end else begin
                if (!m_empty && !m_ev && (m_stalls != 32'hFFFF_FFFF)) begin
                    m_stalls = m_stalls + 1;
                end
                m_pop = m_ev && dec_ready;
                if (m_pop) begin
                    $display("[TB] decode pc=%h instr=%h pred=%0d", hd.pc, hd.instr, hd.pred);
                    void'(exp_q.pop_front());
                    if (m_sys) begin
                        m_blocked = 1;
                        m_seen    = 0;
                        m_ok      = 0;
                    end
                end else if (m_blocked) begin
                    if (rob_empty) m_blocked = 0;
                end else if (m_sys) begin
                    m_seen = 1;
                    if (rob_empty) m_ok = 1;
                end
            end
        end
    end

    // One clock of stimulus; the entry is recorded as expected once accepted.
    task automatic step(input bit fv, input logic [31:0] ins, input logic [63:0] pcv,
                        input bit pr, input bit dr, input bit rob, input bit fl,
                        output bit acc);
        fetch_valid      = fv;
        fetch_instr      = ins;
        fetch_pc         = pcv;
        fetch_pred_taken = pr;
        dec_ready        = dr;
        rob_empty        = rob;
        flush            = fl;
        @(negedge clk);
        acc = fv && fetch_ready && !fl && reset_n;
        @(posedge clk);
        #1;
        if (acc) exp_q.push_back('{instr: ins, pc: pcv, pred: pr});
        fetch_valid = 1'b0;
        flush       = 1'b0;
    endtask

    logic [63:0] next_pc = 64'h1000;

    task automatic push_n(input int n, input bit dr, input bit rob,
                          input logic [31:0] ins, input int budget);
        int  done = 0;
        bit  acc;
        for (int c = 0; c < budget && done < n; c++) begin
            step(1'b1, ins, next_pc, next_pc[4], dr, rob, 1'b0, acc);
            if (acc) begin
                done++;
                next_pc = next_pc + 64'd4;
            end
        end
        tests++;
        if (done != n) begin
            fails++;
            $display("FAIL push_timeout: got %0d accepted expected %0d", done, n);
        end
    endtask

    task automatic idle(input int n, input bit dr, input bit rob);
        bit acc;
        for (int c = 0; c < n; c++) step(1'b0, '0, '0, 1'b0, dr, rob, 1'b0, acc);
    endtask

    initial begin
        bit          acc;
        logic [31:0] r_ins;
        bit          r_pr;
        bit          have;

        // Reset
        reset_n = 1'b0;
        idle(2, 1'b0, 1'b1);
        reset_n = 1'b1;
        idle(2, 1'b0, 1'b1);

        // Streaming: eight ADDIs, each decoded the cycle after its push
        push_n(8, 1'b1, 1'b1, ADDI, 20);
        idle(3, 1'b1, 1'b1);

        // Backpressure: fill, then the fifth is held until space frees
        push_n(4, 1'b0, 1'b1, ADDI, 10);
        idle(2, 1'b0, 1'b1);
        push_n(1, 1'b1, 1'b1, ADDI, 10);
        idle(6, 1'b1, 1'b1);

        // Serialization: ecall behind ADDI, ROB busy, then the follower waits
        push_n(1, 1'b1, 1'b0, ADDI, 5);
        push_n(1, 1'b1, 1'b0, ECALL, 5);
        push_n(1, 1'b1, 1'b0, ADDI, 5);
        idle(3, 1'b1, 1'b0);
        idle(1, 1'b1, 1'b1);
        idle(1, 1'b1, 1'b0);
        idle(3, 1'b1, 1'b0);
        idle(3, 1'b1, 1'b1);

        // Back-to-back ecalls each take the full sequence
        push_n(2, 1'b1, 1'b0, ECALL, 6);
        idle(2, 1'b1, 1'b0);
        idle(10, 1'b1, 1'b1);

        // Flush mid-DRAIN with ecall and two more buffered
        push_n(1, 1'b1, 1'b0, ECALL, 5);
        push_n(2, 1'b1, 1'b0, ADDI, 5);
        idle(2, 1'b1, 1'b0);
        step(1'b1, ADDI, next_pc, 1'b0, 1'b1, 1'b0, 1'b1, acc);
        idle(2, 1'b1, 1'b0);
        idle(2, 1'b1, 1'b1);

        // Reset mid-ISSUE, then normal streaming resumes
        push_n(1, 1'b0, 1'b1, ECALL, 5);
        idle(2, 1'b0, 1'b1);
        reset_n = 1'b0;
        idle(1, 1'b0, 1'b1);
        reset_n = 1'b1;
        push_n(1, 1'b1, 1'b1, ADDI, 5);
        idle(3, 1'b1, 1'b1);

        // Wrap: hold occupancy at two with a push and pop every cycle
        push_n(2, 1'b0, 1'b1, ADDI, 5);
        push_n(10, 1'b1, 1'b1, ADDI, 12);
        idle(4, 1'b1, 1'b1);

        // Randomized traffic, including ecalls and occasional flushes
        have = 0;
        r_ins = '0;
        r_pr = 0;
        for (int c = 0; c < 400; c++) begin
            if (!have) begin
                if ($urandom_range(0, 5) == 0) begin
                    r_ins = ECALL;
                end else begin
                    r_ins = $urandom;
                    if (r_ins[6:0] == 7'h73) r_ins[6:0] = 7'h13;
                end
                r_pr = 1'($urandom_range(0, 1));
                have = ($urandom_range(0, 3) != 0);
            end
            step(have, r_ins, next_pc, r_pr, ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0), acc);
            if (acc) begin
                have = 0;
                next_pc = next_pc + 64'd4;
            end
        end
        idle(12, 1'b1, 1'b1);
        chk("final_drain", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case the run ever stalls.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_decode_dispatch_ctrl
